// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC iteration controller: FSM state
// encoding and the default micro-rotation count.
package cordic_pkg;

  localparam int DefaultIterations = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_t;

endpackage

// File: rtl/iter_counter.sv
// Iteration index for the CORDIC controller. The index doubles as the
// barrel-shift amount and the arctan ROM address. It is cleared on request,
// stepped on request, and flags the last micro-rotation.
module iter_counter
  import cordic_pkg::*;
#(
  parameter int Iterations = DefaultIterations,
  parameter int CntWidth   = $clog2(Iterations)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic                tc,
  output logic [CntWidth-1:0] count
);

  localparam logic [CntWidth-1:0] LastIndex = CntWidth'(Iterations - 1);

  // Index register: clear takes priority over increment.
  // NOTE: registered state is always written with <= so every flop samples
  // its inputs before any of them update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LastIndex);

endmodule

// File: rtl/cordic_ctrl.sv
// Moore FSM sequencing an iterative CORDIC datapath:
// IDLE -> LOAD (mux picks initial operands) -> ITER (Iterations cycles of
// feedback) -> DONE (result held until the consumer acks).
// Optional feature: define CORDIC_CTRL_ABORT_EN to add abort_i, which
// returns the FSM to IDLE from any state without producing a result.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int Iterations = DefaultIterations,
  parameter int CntWidth   = $clog2(Iterations)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                mode_i,
`ifdef CORDIC_CTRL_ABORT_EN
  input  logic                abort_i,
`endif
  input  logic                ack_i,
  output logic                ready_o,
  output logic                sel_o,
  output logic                en_o,
  output logic [CntWidth-1:0] iter_o,
  output logic                mode_o,
  output logic                valid_o
);

  cordic_state_t state;
  cordic_state_t state_next;
  logic          accept;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          cnt_tc;

  // Next-state logic; an abort, when built in, overrides every transition.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start_i) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_ITER;
      ST_ITER: if (cnt_tc) state_next = ST_DONE;
      ST_DONE: if (ack_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
`ifdef CORDIC_CTRL_ABORT_EN
    if (abort_i) state_next = ST_IDLE;
`endif
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Acceptance is derived from the chosen transition so an abort in IDLE
  // also suppresses the mode capture.
  assign accept = (state == ST_IDLE) && (state_next == ST_LOAD);

  // Mode captured at acceptance and held for the whole operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_o <= 1'b0;
    end else if (accept) begin
      mode_o <= mode_i;
    end
  end

  // Any return to IDLE (ack or abort) clears the index; it only advances
  // inside ITER and stops on the last micro-rotation so DONE shows it.
  assign cnt_clr = (state_next == ST_IDLE);
  assign cnt_inc = (state == ST_ITER) && !cnt_tc;

  iter_counter #(
    .Iterations (Iterations),
    .CntWidth   (CntWidth)
  ) u_iter_counter (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .tc    (cnt_tc),
    .count (iter_o)
  );

  // Moore outputs decoded from state only.
  assign ready_o = (state == ST_IDLE);
  assign valid_o = (state == ST_DONE);
  assign sel_o   = (state == ST_ITER);
  assign en_o    = (state == ST_LOAD) || (state == ST_ITER);

endmodule

// File: tb/tb_cordic_ctrl.sv
// Bench for cordic_ctrl. Each accepted operation pushes its expected result
// (mode and the cycle valid_o must rise in) onto a queue; an independent
// monitor pops and compares whenever valid_o rises. Directed tasks also
// check the per-cycle control outputs.
module tb_cordic_ctrl;
  import cordic_pkg::*;

  localparam int Iterations = DefaultIterations;
  localparam int CntWidth   = $clog2(Iterations);

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                start_i;
  logic                mode_i;
  logic                ack_i;
`ifdef CORDIC_CTRL_ABORT_EN
  logic                abort_i;
`endif
  logic                ready_o;
  logic                sel_o;
  logic                en_o;
  logic [CntWidth-1:0] iter_o;
  logic                mode_o;
  logic                valid_o;

  typedef struct {
    logic mode;
    int   cycle;
  } exp_t;

  exp_t exp_q[$];
  int   cyc        = 0;
  int   n_checks   = 0;
  int   n_pass     = 0;
  logic valid_prev = 1'b0;

  cordic_ctrl #(
    .Iterations (Iterations),
    .CntWidth   (CntWidth)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .mode_i  (mode_i),
`ifdef CORDIC_CTRL_ABORT_EN
    .abort_i (abort_i),
`endif
    .ack_i   (ack_i),
    .ready_o (ready_o),
    .sel_o   (sel_o),
    .en_o    (en_o),
    .iter_o  (iter_o),
    .mode_o  (mode_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle index: the value during a cycle is the number of rising edges so far.
  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_outs(input string name, input logic r, input logic v,
                            input logic s, input logic e, input int it);
    n_checks++;
    if (ready_o === r && valid_o === v && sel_o === s && en_o === e && int'(iter_o) == it)
      n_pass++;
    else
      $display("FAIL %s: got ready=%b valid=%b sel=%b en=%b iter=%0d expected ready=%b valid=%b sel=%b en=%b iter=%0d (t=%0t)",
               name, ready_o, valid_o, sel_o, en_o, iter_o, r, v, s, e, it, $time);
  endtask

  // Monitor: every rising valid_o must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1 && valid_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got valid=1 expected no result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_cycle", cyc, e.cycle);
        check("valid_mode", int'(mode_o), int'(e.mode));
        check("valid_iter", int'(iter_o), Iterations - 1);
      end
    end
    valid_prev = valid_o;
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Start an operation; the request cycle counts as cycle 0, LOAD is
  // cycle 1, ITER cycles 2..Iterations+1, so DONE is cycle Iterations+2.
  task automatic issue(input logic m);
    exp_t e;
    start_i = 1'b1;
    mode_i  = m;
    e.mode  = m;
    e.cycle = cyc + Iterations + 2;
    exp_q.push_back(e);
    tick();
    start_i = 1'b0;
    check_outs("load", 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  // Walk from LOAD through every ITER cycle into DONE; with poke set,
  // start_i is held high and mode_i toggled to prove they are ignored.
  task automatic run_iters(input logic exp_mode, input bit poke);
    for (int i = 0; i < Iterations; i++) begin
      if (poke) begin
        start_i = 1'b1;
        mode_i  = ~mode_i;
      end
      tick();
      check_outs("iter", 1'b0, 1'b0, 1'b1, 1'b1, i);
      check("iter_mode", int'(mode_o), int'(exp_mode));
    end
    if (poke) begin
      start_i = 1'b1;
      mode_i  = ~mode_i;
    end
    tick();
    check_outs("done_entry", 1'b0, 1'b1, 1'b0, 1'b0, Iterations - 1);
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    check_outs("ack_idle", 1'b1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic wait_iter(input int target);
    int budget;
    budget = 4 * Iterations;
    while (!(sel_o === 1'b1 && int'(iter_o) == target) && budget > 0) begin
      tick();
      budget--;
    end
    check("wait_iter_reached", int'(sel_o === 1'b1 && int'(iter_o) == target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    mode_i  = 1'b0;
    ack_i   = 1'b0;
`ifdef CORDIC_CTRL_ABORT_EN
    abort_i = 1'b0;
`endif
    tick();
    check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("reset_mode", int'(mode_o), 0);
    rst_i = 1'b0;

    // Basic rotation run, then hold DONE for 5 cycles before acking.
    issue(1'b0);
    run_iters(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_outs("done_hold", 1'b0, 1'b1, 1'b0, 1'b0, Iterations - 1);
    end
    do_ack();

    // Vectoring run with start_i held and mode_i toggling in ITER and DONE.
    issue(1'b1);
    run_iters(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      start_i = 1'b1;
      mode_i  = ~mode_i;
      tick();
      check_outs("done_start_ignored", 1'b0, 1'b1, 1'b0, 1'b0, Iterations - 1);
      check("done_mode_kept", int'(mode_o), 1);
    end

    // ack and start together in DONE: only the ack is taken.
    start_i = 1'b1;
    mode_i  = 1'b1;
    ack_i   = 1'b1;
    tick();
    ack_i = 1'b0;
    check_outs("ack_with_start", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("ack_with_start_mode", int'(mode_o), 1);

    // start_i still high in the following IDLE cycle is accepted.
    issue(1'b0);
    check("restart_mode", int'(mode_o), 0);
    run_iters(1'b0, 1'b0);
    do_ack();

    // Asynchronous reset mid-ITER, then a full run straight after release.
    issue(1'b1);
    wait_iter(7);
    #2 rst_i = 1'b1;
    #1;
    check_outs("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("async_reset_mode", int'(mode_o), 0);
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    issue(1'b0);
    run_iters(1'b0, 1'b0);
    do_ack();

`ifdef CORDIC_CTRL_ABORT_EN
    // Abort mid-ITER: back to IDLE with no result.
    issue(1'b1);
    wait_iter(4);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    exp_q.delete();
    check_outs("abort_idle", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Abort beats start in IDLE.
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    check_outs("abort_over_start", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs("abort_stays_idle", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    end
`endif

    repeat (3) tick();
    check("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
